mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one unified instruction/data memory between the processor's instruction-fetch port and its load/store data port. It sits between the core and the memory array, which has an asynchronous read and a write that commits on the clock edge. The arbiter sequences each access through a small FSM, latches the winning request, and returns read data through registered, one-cycle `ready` pulses. The core uses `busy` and the two `ready` outputs to stall fetch or memory stages while the other port is being served.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Each access runs through a short FSM: SERVE drives the memory, and RESP pulses ready.
module mem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_IF,
        SERVE_D,
        RESP_IF,
        RESP_D
    } state_t;

    state_t state;

    // The memory-side outputs are the request latch: loaded on grant, held through SERVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= IDLE;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (d_req && (!if_req || D_PRIORITY)) begin
                        state     <= SERVE_D;
                        busy      <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_wdata <= d_we ? d_wdata : '0;
                    end else if (if_req) begin
                        state    <= SERVE_IF;
                        busy     <= 1'b1;
                        mem_addr <= if_addr;
                    end
                end
                SERVE_IF: begin
                    if_rdata <= mem_rdata;
                    if_ready <= 1'b1;
                    busy     <= 1'b1;
                    state    <= RESP_IF;
                end
                SERVE_D: begin
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                    d_ready <= 1'b1;
                    busy    <= 1'b1;
                    state   <= RESP_D;
                end
                // Only the other port may win here, which forces alternation under contention.
                RESP_IF: begin
                    if (d_req) begin
                        state     <= SERVE_D;
                        busy      <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_wdata <= d_we ? d_wdata : '0;
                    end
                end
                RESP_D: begin
                    if (if_req) begin
                        state    <= SERVE_IF;
                        busy     <= 1'b1;
                        mem_addr <= if_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural memory model.
// Cycle k means k rising edges after the inputs for cycle 0 were applied.
module tb_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    logic [DATA_W-1:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .D_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory array: asynchronous read, write committed on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({if_ready, d_ready, busy, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got busy=%b mem_we=%b mem_addr=%h if_rdata=%h d_rdata=%h expected all zero",
                     busy, mem_we, mem_addr, if_rdata, d_rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 6'd2;
        step();
        checks++;
        if (mem_addr !== 6'd2 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_serve got mem_addr=%0d busy=%b expected 2 1", mem_addr, busy);
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h00208193) begin
            errors++;
            $display("[TB] FAIL fetch_ready got ready=%b rdata=%h expected 1 00208193", if_ready, if_rdata);
        end
        if_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || if_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_idle got busy=%b ready=%b expected 0 0", busy, if_ready);
        end
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 6'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd1;
        step();
        checks++;
        if (mem_addr !== 6'd1 || mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_serve_d got mem_addr=%0d mem_we=%b expected 1 0", mem_addr, mem_we);
        end
        step();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'd10 || if_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_d_ready got d_ready=%b d_rdata=%h if_ready=%b expected 1 0000000a 0",
                     d_ready, d_rdata, if_ready);
        end
        d_req = 1'b0;
        step();
        checks++;
        if (mem_addr !== 6'd5 || busy !== 1'b1 || d_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_serve_if got mem_addr=%0d busy=%b d_ready=%b expected 5 1 0",
                     mem_addr, busy, d_ready);
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h00000513) begin
            errors++;
            $display("[TB] FAIL sim_if_ready got ready=%b rdata=%h expected 1 00000513", if_ready, if_rdata);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wdata = 32'd30;
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd3 || mem_wdata !== 32'd30) begin
            errors++;
            $display("[TB] FAIL store_serve got we=%b addr=%0d wdata=%0d expected 1 3 30", mem_we, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (d_ready !== 1'b1 || mem_we !== 1'b0 || d_rdata !== 32'd10) begin
            errors++;
            $display("[TB] FAIL store_ready got d_ready=%b mem_we=%b d_rdata=%0d expected 1 0 10",
                     d_ready, mem_we, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        step();
        d_req = 1'b1; d_addr = 6'd3;
        step();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 6'd3) begin
            errors++;
            $display("[TB] FAIL load_serve got we=%b addr=%0d expected 0 3", mem_we, mem_addr);
        end
        step();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'd30) begin
            errors++;
            $display("[TB] FAIL load_after_store got d_ready=%b d_rdata=%0d expected 1 30", d_ready, d_rdata);
        end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic exp_d, exp_if, exp_we;
        if_req = 1'b1; if_addr = 6'd11;
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd10; d_wdata = 32'h55;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_d  = (c % 4 == 2);
            exp_if = (c % 4 == 0);
            exp_we = (c % 4 == 1);
            checks++;
            if (d_ready !== exp_d || if_ready !== exp_if || mem_we !== exp_we || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL contention_c%0d got d_ready=%b if_ready=%b mem_we=%b busy=%b expected %b %b %b 1",
                         c, d_ready, if_ready, mem_we, busy, exp_d, exp_if, exp_we);
            end
            if (c == 12) begin
                if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || mem[10] !== 32'h55 || if_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL contention_end got busy=%b mem10=%h if_rdata=%h expected 0 00000055 00000000",
                     busy, mem[10], if_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_r;
        if_req = 1'b1; if_addr = 6'd2;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_r = (c == 2 || c == 5 || c == 8);
            checks++;
            if (if_ready !== exp_r || d_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_c%0d got if_ready=%b d_ready=%b expected %b 0", c, if_ready, d_ready, exp_r);
            end
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_withdrawn();
        if_req = 1'b1; if_addr = 6'd2;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd7;
        step();
        d_req = 1'b0; if_req = 1'b0;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL withdraw_if_ready got %b expected 1", if_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0 || mem_addr !== 6'd0) begin
            errors++;
            $display("[TB] FAIL withdraw_idle got busy=%b mem_addr=%0d expected 0 0", busy, mem_addr);
        end
        step();
        checks++;
        if (d_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL withdraw_no_access got d_ready=%b busy=%b expected 0 0", d_ready, busy);
        end
    endtask

    task automatic test_reset_mid_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd4; d_wdata = 32'd20;
        step();
        rst = 1'b1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd4) begin
            errors++;
            $display("[TB] FAIL rst_store_serve got we=%b addr=%0d expected 1 4", mem_we, mem_addr);
        end
        step();
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        checks++;
        if ({if_ready, d_ready, busy, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_store_outputs got d_ready=%b busy=%b mem_we=%b mem_addr=%0d d_rdata=%h expected all zero",
                     d_ready, busy, mem_we, mem_addr, d_rdata);
        end
        checks++;
        if (mem[4] !== 32'd20) begin
            errors++;
            $display("[TB] FAIL rst_store_commit got mem4=%0d expected 20", mem[4]);
        end
        step();
        checks++;
        if (d_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_store_no_ready got d_ready=%b busy=%b expected 0 0", d_ready, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1] = 32'd10;
        mem[2] = 32'h00208193;
        mem[5] = 32'h00000513;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_withdrawn();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
